// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads imem over req/ready and feeds a
// single-entry buffer into IF/ID, emitting a nop whenever the buffer is empty.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        r,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] instruction_if,
  output logic        valid_if
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_inst;
  logic         fill;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc;
    state_next = state;
    fill       = 1'b0;
    unique case (state)
      RUN: begin
        imem_req = !valid_if || en;
        if (imem_req && imem_ready)
          fill = 1'b1;
        else if (imem_req)
          state_next = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fill       = 1'b1;
          state_next = RUN;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (imem_ready)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // A redirect never withdraws an outstanding request; it drains it instead.
    if (redirect) begin
      fill       = 1'b0;
      state_next = (imem_req && !imem_ready) ? DRAIN : RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state      <= RUN;
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
      buf_pc     <= 32'h0;
      buf_inst   <= 32'h0;
      valid_if   <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc       <= redirect_pc;
        valid_if <= 1'b0;
        if (state_next == DRAIN)
          drain_addr <= imem_addr;
      end else if (fill) begin
        buf_pc   <= pc;
        buf_inst <= imem_rdata;
        valid_if <= 1'b1;
        pc       <= pc + INSTR_BYTES;
      end else if (state_next == WAIT) begin
        valid_if <= 1'b0;
      end
    end
  end

  assign PC_if          = buf_pc;
  assign instruction_if = valid_if ? buf_inst : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; memory returns addr + 0x1000_0000 as the word.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        r;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_if;
  logic [31:0] instruction_if;
  logic        valid_if;

  int total = 0;
  int bad   = 0;

  if_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .r              (r),
    .en             (en),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .PC_if          (PC_if),
    .instruction_if (instruction_if),
    .valid_if       (valid_if)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h1000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r           = 1'b1;
    en          = 1'b1;
    imem_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    r = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; en = 1'b1; imem_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    #2;
    total++;
    if ({valid_if, PC_if, instruction_if} !== {1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL rst_outputs got=%h exp=%h", {valid_if, PC_if, instruction_if}, {1'b0, 32'h0, 32'h0});
    end
    tick();
    tick();
    r = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_3000}) begin
      bad++;
      $display("FAIL rst_first_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0000_3000});
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({valid_if, PC_if, instruction_if, imem_addr} !==
          {1'b1, exp_pc[i], exp_pc[i] + 32'h1000_0000, exp_pc[i] + 32'd4}) begin
        bad++;
        $display("FAIL stream_%0d got pc=%h inst=%h v=%b addr=%h exp pc=%h", i,
                 PC_if, instruction_if, valid_if, imem_addr, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({imem_req, valid_if, PC_if, instruction_if} !== {1'b0, 1'b1, 32'h3008, 32'h1000_3008}) begin
        bad++;
        $display("FAIL stall_%0d got req=%b v=%b pc=%h inst=%h exp req=0 pc=3008", i,
                 imem_req, valid_if, PC_if, instruction_if);
      end
      tick();
    end
    en = 1'b1;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h300C}) begin
      bad++;
      $display("FAIL stall_resume_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h300C});
    end
    tick();
    total++;
    if ({valid_if, PC_if} !== {1'b1, 32'h300C}) begin
      bad++;
      $display("FAIL stall_resume_pc got=%h exp=%h", {valid_if, PC_if}, {1'b1, 32'h300C});
    end
  endtask

  task automatic test_wait();
    do_reset();
    tick();                 // fills 0x3000
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h3004}) begin
        bad++;
        $display("FAIL wait_addr_%0d got=%h exp=%h", i, {imem_req, imem_addr}, {1'b1, 32'h3004});
      end
      if (i == 2) imem_ready = 1'b1;
      tick();
      if (i < 2) begin
        total++;
        if ({valid_if, instruction_if} !== {1'b0, 32'h0}) begin
          bad++;
          $display("FAIL wait_bubble_%0d got v=%b inst=%h exp v=0 inst=0", i, valid_if, instruction_if);
        end
      end
    end
    total++;
    if ({valid_if, PC_if, instruction_if} !== {1'b1, 32'h3004, 32'h1000_3004}) begin
      bad++;
      $display("FAIL wait_fill got pc=%h inst=%h v=%b exp pc=3004 inst=10003004", PC_if, instruction_if, valid_if);
    end
  endtask

  task automatic test_redirect_drain();
    imem_ready = 1'b0;
    tick();                 // RUN -> WAIT on 0x3008
    redirect = 1'b1;
    redirect_pc = 32'h3100;
    tick();                 // WAIT + redirect -> DRAIN
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({imem_req, imem_addr, valid_if} !== {1'b1, 32'h3008, 1'b0}) begin
        bad++;
        $display("FAIL drain_hold_%0d got req=%b addr=%h v=%b exp addr=3008 v=0", i,
                 imem_req, imem_addr, valid_if);
      end
      if (i == 1) imem_ready = 1'b1;
      tick();
    end
    total++;
    if ({valid_if, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h3100}) begin
      bad++;
      $display("FAIL drain_done got v=%b req=%b addr=%h exp v=0 addr=3100", valid_if, imem_req, imem_addr);
    end
    tick();
    total++;
    if ({valid_if, PC_if, instruction_if} !== {1'b1, 32'h3100, 32'h1000_3100}) begin
      bad++;
      $display("FAIL drain_first_valid got pc=%h inst=%h v=%b exp pc=3100", PC_if, instruction_if, valid_if);
    end
  endtask

  task automatic test_redirect_collision();
    en = 1'b1; imem_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    tick();
    redirect = 1'b0;
    #1;
    total++;
    if ({valid_if, instruction_if, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h4000}) begin
      bad++;
      $display("FAIL collide_bubble got v=%b inst=%h req=%b addr=%h exp v=0 addr=4000",
               valid_if, instruction_if, imem_req, imem_addr);
    end
    tick();
    total++;
    if ({valid_if, PC_if} !== {1'b1, 32'h4000}) begin
      bad++;
      $display("FAIL collide_refill got=%h exp=%h", {valid_if, PC_if}, {1'b1, 32'h4000});
    end
  endtask

  task automatic test_wrap_and_misaligned();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if ({PC_if, instruction_if, imem_addr} !== {32'hFFFF_FFFC, 32'h0FFF_FFFC, 32'h0}) begin
      bad++;
      $display("FAIL wrap got pc=%h inst=%h addr=%h exp pc=fffffffc inst=0ffffffc addr=0",
               PC_if, instruction_if, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if ({valid_if, PC_if, imem_addr} !== {1'b1, 32'h102, 32'h106}) begin
      bad++;
      $display("FAIL misaligned got v=%b pc=%h addr=%h exp pc=102 addr=106", valid_if, PC_if, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();                 // fills 0x3000
    imem_ready = 1'b0;
    tick();                 // now in WAIT on 0x3004
    #2;
    r = 1'b1;
    #1;
    total++;
    if ({valid_if, PC_if, instruction_if, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h3000}) begin
      bad++;
      $display("FAIL rst_mid_wait got v=%b pc=%h inst=%h addr=%h exp all 0 addr=3000",
               valid_if, PC_if, instruction_if, imem_addr);
    end
    r = 1'b0;
    imem_ready = 1'b1;
    tick();
    total++;
    if ({valid_if, PC_if} !== {1'b1, 32'h3000}) begin
      bad++;
      $display("FAIL rst_mid_wait_refetch got=%h exp=%h", {valid_if, PC_if}, {1'b1, 32'h3000});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_redirect_drain();
    test_redirect_collision();
    test_wrap_and_misaligned();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the five-stage pipeline: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and presents `PC_if` and `instruction_if` to the IF/ID pipeline register. It is the producer end of that register, and it honours the same `en` the hazard unit drives into IF/ID. When it has no valid instruction it emits a nop (`32'h0`), so IF/ID captures a bubble.

## Interface
- `RESET_PC`, default `32'h0000_3000`: address of the first fetch after reset.
- `clk` in 1: pipeline clock, rising edge.
- `r` in 1: reset, asynchronous, active-high.
- `en` in 1: IF/ID enable from the hazard unit; the presented instruction is consumed on a rising edge where `en`=1.
- `redirect` in 1: taken branch/jump resolved downstream.
- `redirect_pc` in 32: new fetch address, valid when `redirect`=1.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word address of the request.
- `imem_ready` in 1: read completes this cycle.
- `imem_rdata` in 32: read data, valid when `imem_req`&&`imem_ready`.
- `PC_if` out 32: PC of the buffered instruction.
- `instruction_if` out 32: buffered instruction; `32'h0` when `valid_if`=0.
- `valid_if` out 1: buffer holds a real instruction.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `drain_addr`: address of the abandoned request.
  - Single-entry buffer: `buf_pc`, `buf_inst`, `valid_if`.
  - `state`: one of RUN, WAIT, DRAIN.
- Reset values: `state`=RUN, `pc`=`RESET_PC`, `valid_if`=0, `buf_pc`=0, `buf_inst`=0.
  - Hence `PC_if`=0 and `instruction_if`=0 during reset, and `imem_req`=1 immediately after reset.
- RUN:
  - `imem_req` = !`valid_if` || `en`; `imem_addr`=`pc`.
  - If `imem_req`&&`imem_ready`: buffer←{`pc`,`imem_rdata`}, `valid_if`←1, `pc`←`pc`+4. Stay in RUN.
  - If `imem_req`&&!`imem_ready`: `valid_if`←0, go to WAIT.
  - If !`imem_req` (stalled, buffer full): hold everything.
- WAIT:
  - `imem_req`=1; `imem_addr`=`pc`, held stable.
  - `valid_if` is 0 throughout this state.
  - On `imem_ready`: fill the buffer as in RUN, go to RUN.
- DRAIN:
  - `imem_req`=1; `imem_addr`=`drain_addr`.
  - On `imem_ready`: discard `imem_rdata`, go to RUN.
- Redirect (any state) has priority over the fill and over `en`:
  - `pc`←`redirect_pc`; `valid_if`←0.
  - Any `imem_rdata` arriving that cycle is discarded.
  - Next state:
    - DRAIN, with `drain_addr`←current `imem_addr`, if a request is outstanding and `imem_ready`=0 (RUN with `imem_req`&&!`imem_ready`, or WAIT without ready).
    - DRAIN if already in DRAIN without ready.
    - RUN otherwise.
- Handshake rule: once `imem_req` is asserted without `imem_ready`, `imem_req` and `imem_addr` stay constant until `imem_ready`. Redirect never withdraws a request; it drains it.
- Arithmetic:
  - `pc`+4 is 32-bit and wraps modulo 2^32.
  - `redirect_pc` bits[1:0] are taken as given; alignment is not checked.

## Timing
- Fill latency: `imem_ready` at edge N puts the instruction on `instruction_if` after edge N (registered output; no combinational path from `imem_rdata`).
- Zero-wait memory with `en`=1: one instruction per cycle; sequential PCs appear on consecutive cycles.
- Redirect penalty with zero-wait memory: one bubble cycle after the redirect edge, plus any DRAIN cycles.
- Downstream stall (`en`=0, buffer full): outputs held, `imem_req`=0.
- Reset asserted mid-WAIT or mid-DRAIN: immediate return to reset values; the outstanding request is abandoned. Memory is reset by the same `r`.

## Structure
- Shared package `if_pkg`:
  - State enum {RUN, WAIT, DRAIN}.
  - `NOP_INSTR`=`32'h0`.
  - `INSTR_BYTES`=4.
- No sub-module: one always_ff for the state and registers, one always_comb for `imem_req`/`imem_addr`/next state.

## Test plan
- Reset release, `RESET_PC`=`0x3000`, `imem_ready`=1, `en`=1 → `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles; `PC_if` follows one cycle later with `valid_if`=1.
- `en`=0 for 3 cycles with the buffer full → `PC_if`/`instruction_if` constant, `imem_req`=0; resumes at the next address when `en`=1.
- Memory 2-cycle wait at 0x3004 → `imem_addr` held at 0x3004 for 3 cycles; `valid_if`=0 and `instruction_if`=0 meanwhile; then data appears with `PC_if`=0x3004.
- `redirect`=1, `redirect_pc`=0x3100 while in WAIT on 0x3008 → DRAIN keeps `imem_addr`=0x3008 until ready, data discarded; next request is 0x3100 and the first valid `PC_if` is 0x3100.
- `redirect`, `imem_ready` and `en` all asserted in the same cycle → `imem_rdata` dropped, `valid_if`=0 next cycle, next `imem_addr`=`redirect_pc`.
- `r` pulsed mid-WAIT, between clock edges → `valid_if`, `PC_if`, `instruction_if` drop to 0 before the next edge; the first fetch after release is at `RESET_PC`.
